// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module  : instr_fetch_pkg
// Brief   : Shared constants, encodings and types for the instruction fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam logic [1:0] SEL_BR = 2'b00;
    localparam logic [1:0] SEL_J  = 2'b01;
    localparam logic [1:0] SEL_JR = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } q_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module  : instr_fetch_if
// Brief   : Memory handshake and decode-facing signals of the fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        IF_valid;
    logic [31:0] IF_instr;
    logic [31:0] IF_pc;
    logic        ID_ready;
    logic        ID_redirect_en;
    logic [1:0]  ID_redirect_sel;
    logic [31:0] ID_pc;
    logic [15:0] ID_imme;
    logic [25:0] ID_j_imme;
    logic [31:0] ID_read_rs_data;

    modport master (
        output inst_req, inst_addr, IF_valid, IF_instr, IF_pc,
        input  inst_ack, inst_rdata, ID_ready, ID_redirect_en, ID_redirect_sel,
               ID_pc, ID_imme, ID_j_imme, ID_read_rs_data
    );

    modport slave (
        input  inst_req, inst_addr, IF_valid, IF_instr, IF_pc,
        output inst_ack, inst_rdata, ID_ready, ID_redirect_en, ID_redirect_sel,
               ID_pc, ID_imme, ID_j_imme, ID_read_rs_data
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_target.sv
// ============================================================================
// Module  : fetch_target
// Brief   : Combinational redirect target for branch, jump and jump-register
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_target
    import instr_fetch_pkg::*;
(
    input  wire logic [1:0]  redirect_sel_i,
    input  wire logic [31:0] pc_i,
    input  wire logic [15:0] imme_i,
    input  wire logic [25:0] j_imme_i,
    input  wire logic [31:0] rs_data_i,
    output logic      [31:0] target_o
);

    logic [31:0] w_seq_pc;
    logic [31:0] w_br_off;

    assign w_seq_pc = pc_i + 32'd4;
    assign w_br_off = {{14{imme_i[15]}}, imme_i, 2'b00};

    // The reserved select value falls through to the register target
    always_comb begin
        target_o = rs_data_i & 32'hFFFF_FFFC;
        case (redirect_sel_i)
            SEL_BR:  target_o = w_seq_pc + w_br_off;
            SEL_J:   target_o = {w_seq_pc[31:28], j_imme_i, 2'b00};
            default: target_o = rs_data_i & 32'hFFFF_FFFC;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module  : instr_fetch
// Brief   : PC, fetch FSM (BOOT/REQ/DROP) and 2-entry instruction queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  wire logic     clk,
    input  wire logic     rst,
    instr_fetch_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic [1:0]   count_q, count_d;
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    q_entry_t     entries_q [2];

    logic         w_req;
    logic         w_push;
    logic         w_pop;
    logic         w_redirect;
    logic [31:0]  w_target;

    fetch_target u_target (
        .redirect_sel_i (bus.ID_redirect_sel),
        .pc_i           (bus.ID_pc),
        .imme_i         (bus.ID_imme),
        .j_imme_i       (bus.ID_j_imme),
        .rs_data_i      (bus.ID_read_rs_data),
        .target_o       (w_target)
    );

    assign w_redirect = bus.ID_redirect_en;
    // Gating on count<=1 leaves room for the pending word, so no overflow check is needed
    assign w_req  = (state_q == ST_DROP) || ((state_q == ST_REQ) && (count_q <= 2'd1));
    assign w_push = (state_q == ST_REQ) && w_req && bus.inst_ack && !w_redirect;
    assign w_pop  = (count_q != 2'd0) && bus.ID_ready && !w_redirect;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;

        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (w_push) begin
                    pc_d = pc_q + 32'd4;
                end
                if (w_redirect && w_req && !bus.inst_ack) begin
                    state_d     = ST_DROP;
                    drop_addr_d = pc_q;
                end
            end
            ST_DROP: begin
                if (bus.inst_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (w_redirect) begin
            pc_d    = w_target;
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            count_d = count_q + 2'(w_push) - 2'(w_pop);
            head_d  = head_q ^ w_pop;
            tail_d  = tail_q ^ w_push;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            count_q      <= 2'd0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            entries_q[0] <= '0;
            entries_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            if (w_push) begin
                entries_q[tail_q] <= {pc_q, bus.inst_rdata};
            end
        end
    end

    assign bus.inst_req  = w_req;
    assign bus.inst_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    assign bus.IF_valid  = (count_q != 2'd0);
    assign bus.IF_instr  = entries_q[head_q].instr;
    assign bus.IF_pc     = entries_q[head_q].pc;

endmodule

`default_nettype wire
